// File: rtl/Dilithium_pkg.sv
// Shared ML-DSA constants and types for the hint unpacker.
// Holds the default (K, OMEGA) set, the hint matrix type and the unpacker FSM encoding.
package Dilithium_pkg;

  localparam int k        = 4;
  localparam int omega    = 80;
  localparam int poly_len = 256;

  typedef logic [0:k-1][0:poly_len-1] hint_mat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHKCNT,
    S_DECODE,
    S_ZCHK,
    S_DONE,
    S_ERR
  } hbu_state_e;

endpackage

// File: rtl/hint_bit_unpack_buf.sv
// Byte store for one hint field: a single write port and two asynchronous read ports.
// Addresses past the end read back as zero, so an idx-1 underflow is harmless.
module hint_byte_buf #(
  parameter int DEPTH = 84,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [7:0]    o_rdata_a,
  output logic [7:0]    o_rdata_b
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < DEPTH; n++) begin
        r_mem[n] <= '0;
      end
    end else if (i_we && (i_waddr <= LAST_ADDR)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a <= LAST_ADDR) ? r_mem[i_raddr_a] : 8'h00;
  assign o_rdata_b = (i_raddr_b <= LAST_ADDR) ? r_mem[i_raddr_b] : 8'h00;

endmodule

// File: rtl/hint_bit_unpack.sv
// ML-DSA HintBitUnpack: buffers the OMEGA+K hint bytes, validates them one check per cycle
// and rebuilds the K x POLY_LEN hint matrix, or reports the signature as malformed.
module hint_bit_unpack
  import Dilithium_pkg::*;
#(
  parameter int K        = k,
  parameter int OMEGA    = omega,
  parameter int POLY_LEN = poly_len
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [7:0]                  in_byte,
  output logic                        in_ready,
  output logic [0:K-1][0:POLY_LEN-1]  h,
  output logic                        h_valid,
  output logic                        done,
  output logic                        err
);

  localparam int DEPTH = OMEGA + K;
  localparam int AW    = $clog2(DEPTH);
  localparam int IDXW  = $clog2(OMEGA + 1);
  localparam int IW    = (K > 1) ? $clog2(K) : 1;

  localparam logic [AW-1:0]   LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0]   CNT_BASE   = AW'(OMEGA);
  localparam logic [IDXW-1:0] OMEGA_IDX  = IDXW'(OMEGA);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(OMEGA - 1);
  localparam logic [7:0]      OMEGA_BYTE = 8'(OMEGA);
  localparam logic [IW-1:0]   LAST_POLY  = IW'(K - 1);

  hbu_state_e                 r_state;
  logic [AW-1:0]              r_byte_cnt;
  logic [IW-1:0]              r_i;
  logic [IDXW-1:0]            r_idx;
  logic [IDXW-1:0]            r_first;
  logic [IDXW-1:0]            r_c;
  logic [0:K-1][0:POLY_LEN-1] r_h;
  logic                       r_in_ready;
  logic                       r_h_valid;
  logic                       r_done;
  logic                       r_err;

  logic                       w_accept;
  logic [AW-1:0]              w_raddr_a;
  logic [AW-1:0]              w_raddr_b;
  logic [7:0]                 w_rd_a;
  logic [7:0]                 w_rd_b;
  logic                       w_cnt_bad;
  logic [IDXW-1:0]            w_cnt_idx;
  logic                       w_order_bad;
  logic [IDXW-1:0]            w_idx_next;
  logic                       w_last_poly;
  hbu_state_e                 w_poly_next;

  // Port A doubles as the count-byte reader while a polynomial's count is checked.
  assign w_accept    = r_in_ready & in_valid;
  assign w_raddr_a   = (r_state == S_CHKCNT) ? (CNT_BASE + AW'(r_i)) : AW'(r_idx);
  assign w_raddr_b   = AW'(r_idx) - AW'(1);
  assign w_cnt_bad   = (w_rd_a > OMEGA_BYTE) || (w_rd_a < 8'(r_idx));
  assign w_cnt_idx   = IDXW'(w_rd_a);
  assign w_order_bad = (r_idx > r_first) && (w_rd_b >= w_rd_a);
  assign w_idx_next  = (r_state == S_DECODE) ? (r_idx + IDXW'(1)) : r_idx;
  assign w_last_poly = (r_i == LAST_POLY);
  assign w_poly_next = !w_last_poly               ? S_CHKCNT :
                       (w_idx_next == OMEGA_IDX)  ? S_DONE   : S_ZCHK;

  hint_byte_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_we      (w_accept),
    .i_waddr   (r_byte_cnt),
    .i_wdata   (in_byte),
    .i_raddr_a (w_raddr_a),
    .i_raddr_b (w_raddr_b),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_i        <= '0;
      r_idx      <= '0;
      r_first    <= '0;
      r_c        <= '0;
      r_h        <= '0;
      r_in_ready <= 1'b0;
      r_h_valid  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_h        <= '0;
            r_h_valid  <= 1'b0;
            r_byte_cnt <= '0;
            r_in_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + AW'(1);
            if (r_byte_cnt == LAST_ADDR) begin
              r_state    <= S_CHKCNT;
              r_in_ready <= 1'b0;
              r_i        <= '0;
              r_idx      <= '0;
            end
          end
        end
        S_CHKCNT: begin
          if (w_cnt_bad) begin
            r_state <= S_ERR;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_h     <= '0;
          end else begin
            r_first <= r_idx;
            r_c     <= w_cnt_idx;
            if (r_idx < w_cnt_idx) begin
              r_state <= S_DECODE;
            end else begin
              r_state <= w_poly_next;
              r_done  <= (w_poly_next == S_DONE);
              if (!w_last_poly) r_i <= r_i + IW'(1);
            end
          end
        end
        S_DECODE: begin
          // Indices must strictly increase, but only within the current polynomial.
          if (w_order_bad) begin
            r_state <= S_ERR;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_h     <= '0;
          end else begin
            r_h[r_i][w_rd_a] <= 1'b1;
            r_idx            <= w_idx_next;
            if (w_idx_next == r_c) begin
              r_state <= w_poly_next;
              r_done  <= (w_poly_next == S_DONE);
              if (!w_last_poly) r_i <= r_i + IW'(1);
            end
          end
        end
        S_ZCHK: begin
          if (w_rd_a != 8'h00) begin
            r_state <= S_ERR;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_h     <= '0;
          end else begin
            r_idx <= r_idx + IDXW'(1);
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_h_valid <= 1'b1;
          r_state   <= S_IDLE;
        end
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign h        = r_h;
  assign h_valid  = r_h_valid;
  assign done     = r_done;
  assign err      = r_err;

endmodule
